pipe_div_post: RTL and testbench
================================

PIPE_DIV_POST -- requirements
Module: pipe_div_post

Interface
- REQ-001: The module SHALL have parameter DEND_W, default 32, giving the dividend and quotient width.
- REQ-002: The module SHALL have parameter SOR_W, default 32, giving the divisor and remainder width.
- REQ-003: The module SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth; it is a power of 2 and at least 2.
- REQ-004: Port clk, input, 1 bit: the single clock.
- REQ-005: Port rst, input, 1 bit: synchronous, active-high reset.
- REQ-006: Port valid_i, input, 1 bit: the final divider cell's result is valid this cycle.
- REQ-007: Port dividend_i, input, DEND_W+SOR_W bits: the final cell's working register; bits [DEND_W-1:0] hold the quotient magnitude and bits [DEND_W+SOR_W-1:DEND_W] hold the remainder magnitude.
- REQ-008: Port quot_neg_i, input, 1 bit: sideband flag requesting negation of the quotient.
- REQ-009: Port rem_neg_i, input, 1 bit: sideband flag requesting negation of the remainder.
- REQ-010: Port dz_i, input, 1 bit: sideband flag marking a divide-by-zero operation.
- REQ-011: Port m_valid_o, output, 1 bit: a result is available at the output.
- REQ-012: Port m_ready_i, input, 1 bit: the consumer accepts the result this cycle.
- REQ-013: Port quotient_o, output, DEND_W bits: the result quotient.
- REQ-014: Port remainder_o, output, SOR_W bits: the result remainder.
- REQ-015: Port dz_o, output, 1 bit: the result came from a divide-by-zero operation.
- REQ-016: Port level_o, output, clog2(FIFO_DEPTH)+1 bits: the FIFO occupancy.
- REQ-017: Port ovf_o, output, 1 bit: sticky overflow flag.
- REQ-018: Port ovf_clr_i, input, 1 bit: clears ovf_o.

Function
- REQ-019: The module SHALL register a format stage on every clk edge where valid_i=1, and SHALL set its internal fmt_valid equal to the registered valid_i.
- REQ-020: When dz_i=0, the format stage SHALL compute quotient = quot_neg_i ? -Qmag : Qmag, truncated to DEND_W bits in two's complement.
- REQ-021: When dz_i=0, the format stage SHALL compute remainder = rem_neg_i ? -Rmag : Rmag, truncated to SOR_W bits.
- REQ-022: When dz_i=1, the format stage SHALL produce quotient all-ones, remainder 0 and dz=1, ignoring quot_neg_i and rem_neg_i.
- REQ-023: When fmt_valid=1, the module SHALL write the formatted entry into the FIFO.
- REQ-024: A valid_i pulse at cycle N with an empty FIFO SHALL raise m_valid_o at cycle N+2, giving a latency of 2.
- REQ-025: The FIFO SHALL be show-ahead: quotient_o, remainder_o and dz_o present the head entry whenever m_valid_o=1.
- REQ-026: m_valid_o SHALL equal (level_o != 0).
- REQ-027: A read SHALL occur when m_valid_o && m_ready_i; the head then advances on that edge.
- REQ-028: The source SHALL hold outputs stable while m_valid_o=1 and m_ready_i=0.
- REQ-029: The upstream pipeline has no stall, so the module SHALL never backpressure it.
- REQ-030: A write and a read in the same cycle SHALL leave level unchanged, including when level=FIFO_DEPTH; the write is accepted in that case.
- REQ-031: A write with level=FIFO_DEPTH and no read SHALL drop the entry, leave the FIFO contents unchanged, and set ovf_o on that edge.
- REQ-032: A write with level=0 SHALL NOT bypass the FIFO; the data appears one cycle after the write edge.
- REQ-033: Read and write pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-034: ovf_clr_i=1 SHALL clear ovf_o on the next edge, except that a new overflow on the same edge keeps ovf_o=1 (set wins).
- REQ-035: When m_valid_o=0, quotient_o, remainder_o and dz_o are don't-care but SHALL NOT be X after reset.

Reset
- REQ-036: rst=1 at a clk edge SHALL clear fmt_valid, the pointers, level_o, m_valid_o and ovf_o to 0, and SHALL clear the format registers and FIFO storage to 0.
- REQ-037: rst SHALL override all other inputs; results in flight at reset SHALL be discarded.
- REQ-038: The first valid_i accepted after reset deasserts SHALL be sampled on the first edge with rst=0.

Verification
- REQ-039: With DEND_W=SOR_W=8, dividend_i=16'h03_0C, quot_neg_i=0, rem_neg_i=0 and m_ready_i=1, the bench SHALL check that 2 cycles later m_valid_o=1, quotient_o=8'h0C, remainder_o=8'h03 and dz_o=0.
- REQ-040: With dividend_i=16'h01_05, quot_neg_i=1 and rem_neg_i=1, the bench SHALL check quotient_o=8'hFB and remainder_o=8'hFF.
- REQ-041: With dz_i=1 and arbitrary dividend_i, the bench SHALL check quotient_o=8'hFF, remainder_o=8'h00 and dz_o=1.
- REQ-042: With m_ready_i=0 and 5 back-to-back valid_i pulses (FIFO_DEPTH=4), the bench SHALL check level_o=4, ovf_o=1, and that 4 reads return the first 4 results in order with the 5th dropped.
- REQ-043: With the FIFO full and a write and a read in the same cycle, the bench SHALL check level_o stays 4, ovf_o stays 0, and that the new entry is returned last.
- REQ-044: Asserting rst with 3 entries queued and 1 entry in the format stage SHALL give level_o=0 and m_valid_o=0 on the next cycle, with no stale output after rst releases; ovf_clr_i asserted together with an overflow SHALL leave ovf_o=1.

Source files
------------

// File: rtl/pipe_div_post.sv
// ---------------------------------------------------------------------------------------------
// pipe_div_post
//
// Post-processing stage for a pipelined restoring divider. It takes the working register of the
// last divider cell, restores the signs of the quotient and remainder (or substitutes the
// divide-by-zero result), and queues the result in a small show-ahead FIFO in front of a
// valid/ready consumer.
//
// The upstream pipeline cannot stall. When the FIFO is full and nothing is read, a new result is
// dropped and the sticky overflow flag is raised.
//
// Parameters
//   DEND_W      dividend / quotient width
//   SOR_W       divisor / remainder width
//   FIFO_DEPTH  output FIFO depth (power of two, >= 2)
//
// Ports
//   clk          single clock
//   rst          synchronous, active-high reset
//   valid_i      final divider cell result valid this cycle
//   dividend_i   final working register: {remainder magnitude, quotient magnitude}
//   quot_neg_i   negate the quotient
//   rem_neg_i    negate the remainder
//   dz_i         operation was a divide by zero
//   m_valid_o    FIFO head is valid (level_o != 0)
//   m_ready_i    consumer accepts the head this cycle
//   quotient_o   head quotient (two's complement)
//   remainder_o  head remainder (two's complement)
//   dz_o         head came from a divide by zero
//   level_o      FIFO occupancy, 0..FIFO_DEPTH
//   ovf_o        sticky overflow flag, set when a result is dropped
//   ovf_clr_i    clear ovf_o; a simultaneous overflow wins
// ---------------------------------------------------------------------------------------------
module pipe_div_post #(
  parameter int unsigned DEND_W     = 32,
  parameter int unsigned SOR_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [DEND_W+SOR_W-1:0]       dividend_i,
  input  logic                          quot_neg_i,
  input  logic                          rem_neg_i,
  input  logic                          dz_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DEND_W-1:0]             quotient_o,
  output logic [SOR_W-1:0]              remainder_o,
  output logic                          dz_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  input  logic                          ovf_clr_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  // -------------------------------------------------------------------------------------------
  // Format stage
  // -------------------------------------------------------------------------------------------
  logic [DEND_W-1:0] q_mag;
  logic [SOR_W-1:0]  r_mag;

  logic [DEND_W-1:0] fmt_quot_d, fmt_quot_q;
  logic [SOR_W-1:0]  fmt_rem_d,  fmt_rem_q;
  logic              fmt_dz_d,   fmt_dz_q;
  logic              fmt_valid_q;

  always_comb begin
    q_mag = dividend_i[DEND_W-1:0];
    r_mag = dividend_i[DEND_W+SOR_W-1:DEND_W];

    if (dz_i) begin
      // Divide by zero: fixed result, sign requests are ignored.
      fmt_quot_d = '1;
      fmt_rem_d  = '0;
      fmt_dz_d   = 1'b1;
    end else begin
      fmt_quot_d = quot_neg_i ? (~q_mag + DEND_W'(1)) : q_mag;
      fmt_rem_d  = rem_neg_i  ? (~r_mag + SOR_W'(1))  : r_mag;
      fmt_dz_d   = 1'b0;
    end
  end

  // The data registers only load on valid_i; the valid bit follows valid_i every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_valid_q <= 1'b0;
      fmt_quot_q  <= '0;
      fmt_rem_q   <= '0;
      fmt_dz_q    <= 1'b0;
    end else begin
      fmt_valid_q <= valid_i;
      if (valid_i) begin
        fmt_quot_q <= fmt_quot_d;
        fmt_rem_q  <= fmt_rem_d;
        fmt_dz_q   <= fmt_dz_d;
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Output FIFO (show-ahead, no bypass)
  // -------------------------------------------------------------------------------------------
  logic [DEND_W-1:0] quot_mem_q [FIFO_DEPTH];
  logic [SOR_W-1:0]  rem_mem_q  [FIFO_DEPTH];
  logic              dz_mem_q   [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;

  logic fifo_empty;
  logic fifo_full;
  logic rd_en;
  logic wr_en;
  logic ovf_set;

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LevelFull);
    rd_en      = !fifo_empty && m_ready_i;
    // When full, a same-cycle read frees the head slot, which is exactly where wr_ptr_q points,
    // so the write can still be accepted and lands at the tail.
    wr_en      = fmt_valid_q && (!fifo_full || rd_en);
    ovf_set    = fmt_valid_q && fifo_full && !rd_en;
  end

  // Storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        quot_mem_q[i] <= '0;
        rem_mem_q[i]  <= '0;
        dz_mem_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      quot_mem_q[wr_ptr_q] <= fmt_quot_q;
      rem_mem_q[wr_ptr_q]  <= fmt_rem_q;
      dz_mem_q[wr_ptr_q]   <= fmt_dz_q;
    end
  end

  // Pointers, occupancy and overflow flag. Pointers are exactly AW bits wide, so they wrap
  // modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase

      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  always_comb begin
    m_valid_o   = !fifo_empty;
    quotient_o  = quot_mem_q[rd_ptr_q];
    remainder_o = rem_mem_q[rd_ptr_q];
    dz_o        = dz_mem_q[rd_ptr_q];
    level_o     = level_q;
    ovf_o       = ovf_q;
  end

endmodule

// File: tb/tb_pipe_div_post.sv
// ---------------------------------------------------------------------------------------------
// tb_pipe_div_post
//
// Bench for pipe_div_post at DEND_W = SOR_W = 8, FIFO_DEPTH = 4. A reference model keeps the
// expected FIFO contents as a queue of formatted results; a monitor compares the DUT output
// against the queue head on every falling edge. Directed sequences cover the sign, divide-by-zero,
// overflow, full-with-read and reset cases, followed by a randomized phase.
// ---------------------------------------------------------------------------------------------
module tb_pipe_div_post;

  localparam int unsigned DW    = 8;
  localparam int unsigned SW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst        = 1'b1;
  logic           valid_i    = 1'b0;
  logic [DW+SW-1:0] dividend_i = '0;
  logic           quot_neg_i = 1'b0;
  logic           rem_neg_i  = 1'b0;
  logic           dz_i       = 1'b0;
  logic           m_ready_i  = 1'b1;
  logic           ovf_clr_i  = 1'b0;

  logic           m_valid_o;
  logic [DW-1:0]  quotient_o;
  logic [SW-1:0]  remainder_o;
  logic           dz_o;
  logic [2:0]     level_o;
  logic           ovf_o;

  pipe_div_post #(
    .DEND_W     (DW),
    .SOR_W      (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .dividend_i  (dividend_i),
    .quot_neg_i  (quot_neg_i),
    .rem_neg_i   (rem_neg_i),
    .dz_i        (dz_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dz_o        (dz_o),
    .level_o     (level_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } entry_t;

  entry_t exp_q[$];
  entry_t pend;
  entry_t m_dummy;
  bit     pend_v = 1'b0;
  bit     m_ovf  = 1'b0;
  bit     m_full;
  bit     m_rd;
  bit     m_new_ovf;
  bit     mon_en = 1'b0;

  function automatic entry_t fmt_ref(input logic [15:0] d, input bit qn, input bit rn,
                                     input bit dz);
    entry_t      e;
    int unsigned qm;
    int unsigned rm;
    qm = d[7:0];
    rm = d[15:8];
    if (dz) begin
      e.q  = 8'd255;
      e.r  = 8'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = 8'(qn ? (256 - qm) % 256 : qm);
      e.r  = 8'(rn ? (256 - rm) % 256 : rm);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_v = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_full    = (exp_q.size() == DEPTH);
      m_rd      = (exp_q.size() != 0) && m_ready_i;
      m_new_ovf = pend_v && m_full && !m_rd;
      if (m_rd) m_dummy = exp_q.pop_front();
      if (pend_v && !m_new_ovf) exp_q.push_back(pend);
      if (m_new_ovf) m_ovf = 1'b1;
      else if (ovf_clr_i) m_ovf = 1'b0;
      pend_v = valid_i;
      if (valid_i) pend = fmt_ref(dividend_i, quot_neg_i, rem_neg_i, dz_i);
    end
  end

  // Monitor: compare the presented output against the expected head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sb_level", 32'(level_o), exp_q.size());
      check("sb_m_valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
      check("sb_ovf", 32'(ovf_o), 32'(m_ovf));
      check("sb_known", 32'($isunknown({quotient_o, remainder_o, dz_o})), 0);
      if (exp_q.size() != 0) begin
        check("sb_quot", 32'(quotient_o), 32'(exp_q[0].q));
        check("sb_rem", 32'(remainder_o), 32'(exp_q[0].r));
        check("sb_dz", 32'(dz_o), 32'(exp_q[0].dz));
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic qn, input logic rn, input logic dz);
    valid_i    = 1'b1;
    dividend_i = d;
    quot_neg_i = qn;
    rem_neg_i  = rn;
    dz_i       = dz;
  endtask

  // One result through an empty FIFO with m_ready_i=1: checks the 2-cycle latency and value.
  task automatic single(input string name, input logic [15:0] d, input logic qn, input logic rn,
                        input logic dz, input logic [7:0] eq, input logic [7:0] er,
                        input logic edz);
    tick();
    drive(d, qn, rn, dz);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    check({name, "_early_valid"}, 32'(m_valid_o), 0);
    @(negedge clk);
    check({name, "_valid"}, 32'(m_valid_o), 1);
    check({name, "_quot"}, 32'(quotient_o), 32'(eq));
    check({name, "_rem"}, 32'(remainder_o), 32'(er));
    check({name, "_dz"}, 32'(dz_o), 32'(edz));
    tick();
  endtask

  // n back-to-back pulses with quotient base+k; returns one cycle after the last pulse.
  task automatic fill(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      drive(base + 16'(k), 1'b0, 1'b0, 1'b0);
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [7:0] first, input int n);
    tick();
    m_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_order"}, 32'(quotient_o), 32'(8'(first + 8'(i))));
    end
    @(negedge clk);
    check({name, "_empty"}, 32'(level_o), 0);
  endtask

  task automatic clear_ovf();
    tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(ovf_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------------------------
  initial begin
    // Reset
    repeat (2) tick();
    @(negedge clk);
    check("rst_level", 32'(level_o), 0);
    check("rst_m_valid", 32'(m_valid_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_known", 32'($isunknown({quotient_o, remainder_o, dz_o})), 0);
    check("rst_quot", 32'(quotient_o), 0);
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Sign handling and divide by zero
    single("pos", 16'h030C, 1'b0, 1'b0, 1'b0, 8'h0C, 8'h03, 1'b0);
    single("neg", 16'h0105, 1'b1, 1'b1, 1'b0, 8'hFB, 8'hFF, 1'b0);
    single("dz", 16'hA5C3, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
    single("negq_only", 16'h0780, 1'b1, 1'b0, 1'b0, 8'h80, 8'h07, 1'b0);

    // Overflow: 5 writes into a depth-4 FIFO with no reads
    m_ready_i = 1'b0;
    fill(16'h0001, 5);
    tick();
    @(negedge clk);
    check("ovf_level", 32'(level_o), 4);
    check("ovf_flag", 32'(ovf_o), 1);
    drain_check("ovf_drain", 8'h01, 4);
    clear_ovf();

    // Full FIFO with simultaneous write and read
    m_ready_i = 1'b0;
    fill(16'h0011, 5);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    @(negedge clk);
    check("fullrw_level", 32'(level_o), 4);
    check("fullrw_ovf", 32'(ovf_o), 0);
    drain_check("fullrw_drain", 8'h12, 4);

    // Reset with 3 queued and 1 in the format stage
    m_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(16'h0040 + 16'(k), 1'b0, 1'b0, 1'b0);
    end
    tick();
    valid_i = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("prerst_level", 32'(level_o), 3);
    @(negedge clk);
    check("rst_mid_level", 32'(level_o), 0);
    check("rst_mid_m_valid", 32'(m_valid_o), 0);
    tick();
    // First valid after reset is sampled on the first edge with rst=0.
    rst       = 1'b0;
    m_ready_i = 1'b1;
    drive(16'h0507, 1'b0, 1'b0, 1'b0);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    check("postrst_level", 32'(level_o), 0);
    check("postrst_quot", 32'(quotient_o), 0);
    @(negedge clk);
    check("postrst_valid", 32'(m_valid_o), 1);
    check("postrst_q", 32'(quotient_o), 32'h07);
    check("postrst_r", 32'(remainder_o), 32'h05);
    @(negedge clk);
    check("postrst_nostale", 32'(level_o), 0);

    // ovf_clr_i together with an overflow: set wins
    m_ready_i = 1'b0;
    fill(16'h0021, 5);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("clr_vs_set_ovf", 32'(ovf_o), 1);
    drain_check("clr_drain", 8'h21, 4);
    clear_ovf();

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      tick();
      rst        = ($urandom_range(0, 199) == 0);
      valid_i    = ($urandom_range(0, 9) < 6);
      dividend_i = 16'($urandom);
      quot_neg_i = 1'($urandom);
      rem_neg_i  = 1'($urandom);
      dz_i       = ($urandom_range(0, 9) == 0);
      m_ready_i  = ((n / 250) % 2 == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      ovf_clr_i  = ($urandom_range(0, 19) == 0);
    end
    tick();
    rst       = 1'b0;
    valid_i   = 1'b0;
    ovf_clr_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("final_level", 32'(level_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
